// File: rtl/io_arbiter.sv
// Two-master, one-slave I/O bus arbiter with round-robin tie-break and a slave-ack timeout.
// Define IO_ARB_LOCK_EN to add per-master lock inputs that hold the grant across acks.
module io_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned ADDR_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [15:0]       m0_dat_i,
  output logic [15:0]       m0_dat_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [15:0]       m1_dat_i,
  output logic [15:0]       m1_dat_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              io_stb_o,
  output logic              io_we_o,
  output logic [ADDR_W-1:0] io_addr_o,
  output logic [15:0]       io_dat_o,
  input  logic [15:0]       io_dat_i,
  input  logic              io_ack_i,
  output logic [1:0]        gnt_o,
  output logic              busy_o
`ifdef IO_ARB_LOCK_EN
  ,
  input  logic              m0_lock_i,
  input  logic              m1_lock_i
`endif
);

  localparam logic [7:0] TmoLimit = 8'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;  // 1: M1 was granted last
  logic [7:0]        cnt_q, cnt_d;

  logic              granted, sel_m1, stb_s, we_s, lock_s, tmo, err;
  logic [ADDR_W-1:0] addr_s;
  logic [15:0]       dat_s;

  always_comb begin
    granted = (state_q != StIdle);
    sel_m1  = (state_q == StGnt1);
    stb_s   = sel_m1 ? m1_stb_i  : m0_stb_i;
    we_s    = sel_m1 ? m1_we_i   : m0_we_i;
    addr_s  = sel_m1 ? m1_addr_i : m0_addr_i;
    dat_s   = sel_m1 ? m1_dat_i  : m0_dat_i;
`ifdef IO_ARB_LOCK_EN
    lock_s  = sel_m1 ? m1_lock_i : m0_lock_i;
`else
    lock_s  = 1'b0;
`endif
    tmo     = granted && (cnt_q == TmoLimit);
    // A slave ack in the timeout cycle wins over the error; an aborted request never errors.
    err     = tmo && stb_s && !io_ack_i;
  end

  always_comb begin
    io_stb_o  = granted && stb_s && !tmo;
    io_we_o   = granted && we_s;
    io_addr_o = granted ? addr_s : '0;
    io_dat_o  = granted ? dat_s : '0;
    m0_ack_o  = (state_q == StGnt0) && (io_ack_i || err);
    m0_err_o  = (state_q == StGnt0) && err;
    m0_dat_o  = (state_q == StGnt0) ? io_dat_i : '0;
    m1_ack_o  = (state_q == StGnt1) && (io_ack_i || err);
    m1_err_o  = (state_q == StGnt1) && err;
    m1_dat_o  = (state_q == StGnt1) ? io_dat_i : '0;
    gnt_o     = {state_q == StGnt1, state_q == StGnt0};
    busy_o    = granted;
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (m0_stb_i && (!m1_stb_i || last_q)) begin
          state_d = StGnt0;
          last_d  = 1'b0;
        end else if (m1_stb_i) begin
          state_d = StGnt1;
          last_d  = 1'b1;
        end
      end
      StGnt0, StGnt1: begin
        if (io_ack_i) begin
          if (lock_s) cnt_d = '0;
          else state_d = StIdle;
        end else if (!stb_s || tmo) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_io_arbiter.sv
// Self-checking bench for io_arbiter: directed cycle table, hand sequences and a random run
// against a transaction-level reference model.
module tb_io_arbiter;

  localparam int TMO = 4;

  logic        clk;
  logic        rst_n;
  logic        m0_stb, m0_we, m1_stb, m1_we;
  logic [15:0] m0_addr, m0_dat, m1_addr, m1_dat;
  logic [15:0] m0_dat_o, m1_dat_o;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic        io_stb, io_we;
  logic [15:0] io_addr, io_dat_o, io_dat_in;
  logic        io_ack_drv, ack_follow, io_ack_w;
  logic [1:0]  gnt;
  logic        busy;
`ifdef IO_ARB_LOCK_EN
  logic        m0_lock, m1_lock;
`endif

  assign io_ack_w = ack_follow ? io_stb : io_ack_drv;

  io_arbiter #(.TIMEOUT(TMO), .ADDR_W(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_dat_i(m0_dat),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_dat_i(m1_dat),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .io_stb_o(io_stb), .io_we_o(io_we), .io_addr_o(io_addr), .io_dat_o(io_dat_o),
    .io_dat_i(io_dat_in), .io_ack_i(io_ack_w),
    .gnt_o(gnt), .busy_o(busy)
`ifdef IO_ARB_LOCK_EN
    , .m0_lock_i(m0_lock), .m1_lock_i(m1_lock)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [72:0] dut_vec;
  assign dut_vec = {gnt, busy, io_stb, io_we, io_addr, io_dat_o,
                    m0_ack, m0_err, m0_dat_o, m1_ack, m1_err, m1_dat_o};

  // Reference model: who owns the bus (-1 none), who won last, cycles waited on the slave.
  int own, last, waited;

  function automatic logic [72:0] model_out();
    logic [1:0]  g = 2'b00;
    logic        b = 1'b0, ios = 1'b0, w = 1'b0, s, tm, er, ak;
    logic [15:0] a = '0, d = '0;
    logic        a0 = 1'b0, e0 = 1'b0, a1 = 1'b0, e1 = 1'b0;
    logic [15:0] d0 = '0, d1 = '0;
    if (own >= 0) begin
      s  = (own == 0) ? m0_stb : m1_stb;
      w  = (own == 0) ? m0_we : m1_we;
      a  = (own == 0) ? m0_addr : m1_addr;
      d  = (own == 0) ? m0_dat : m1_dat;
      tm = (waited == TMO);
      er = tm && s && !io_ack_drv;
      ak = io_ack_drv || er;
      g  = 2'(1 << own);
      b  = 1'b1;
      ios = s && !tm;
      if (own == 0) begin a0 = ak; e0 = er; d0 = io_dat_in; end
      else begin a1 = ak; e1 = er; d1 = io_dat_in; end
    end
    return {g, b, ios, w, a, d, a0, e0, d0, a1, e1, d1};
  endfunction

  task automatic model_edge();
    logic s;
    if (own < 0) begin
      if (m0_stb && m1_stb) own = 1 - last;
      else if (m0_stb) own = 0;
      else if (m1_stb) own = 1;
      if (own >= 0) begin last = own; waited = 0; end
    end else begin
      s = (own == 0) ? m0_stb : m1_stb;
      if (io_ack_drv || !s || waited == TMO) own = -1;
      else waited++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {m0_stb, m0_we, m1_stb, m1_we, io_ack_drv, ack_follow} = '0;
    {m0_addr, m0_dat, m1_addr, m1_dat, io_dat_in} = '0;
`ifdef IO_ARB_LOCK_EN
    {m0_lock, m1_lock} = '0;
`endif
    own = -1; last = 1; waited = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic        s0, s1, ack;
    logic [15:0] dat;
    logic [1:0]  g;
    logic        ios;
    logic [15:0] addr;
    logic        a0, e0;
    logic [15:0] d0;
    logic        a1, e1;
    logic [15:0] d1;
  } vec_t;

  function automatic vec_t mk(logic s0, logic s1, logic ack, logic [15:0] dat, logic [1:0] g,
                              logic ios, logic [15:0] addr, logic a0, logic e0,
                              logic [15:0] d0, logic a1, logic e1, logic [15:0] d1);
    vec_t v;
    v.s0 = s0; v.s1 = s1; v.ack = ack; v.dat = dat; v.g = g; v.ios = ios; v.addr = addr;
    v.a0 = a0; v.e0 = e0; v.d0 = d0; v.a1 = a1; v.e1 = e1; v.d1 = d1;
    return v;
  endfunction

  vec_t       tbl [25];
  logic [1:0] rr_exp [8] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};

  initial begin
    // Cycle table from a fresh reset: write, read, timeout, ack-at-timeout, abort.
    tbl[0]  = mk(0, 0, 0, 16'h0000, 2'b00, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000);
    tbl[1]  = mk(1, 0, 0, 16'h0000, 2'b00, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000);
    tbl[2]  = mk(1, 0, 0, 16'h0000, 2'b01, 1, 16'h0002, 0, 0, 16'h0000, 0, 0, 16'h0000);
    tbl[3]  = mk(1, 0, 0, 16'h0000, 2'b01, 1, 16'h0002, 0, 0, 16'h0000, 0, 0, 16'h0000);
    tbl[4]  = mk(1, 0, 1, 16'h1234, 2'b01, 1, 16'h0002, 1, 0, 16'h1234, 0, 0, 16'h0000);
    tbl[5]  = mk(0, 0, 1, 16'hBEEF, 2'b00, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000);
    tbl[6]  = mk(0, 1, 0, 16'h0000, 2'b00, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000);
    tbl[7]  = mk(0, 1, 1, 16'hBEEF, 2'b10, 1, 16'h0004, 0, 0, 16'h0000, 1, 0, 16'hBEEF);
    tbl[8]  = mk(1, 0, 0, 16'h0000, 2'b00, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000);
    for (int i = 9; i <= 12; i++)
      tbl[i] = mk(1, 0, 0, 16'h0000, 2'b01, 1, 16'h0002, 0, 0, 16'h0000, 0, 0, 16'h0000);
    tbl[13] = mk(1, 0, 0, 16'h0000, 2'b01, 0, 16'h0002, 1, 1, 16'h0000, 0, 0, 16'h0000);
    tbl[14] = mk(0, 0, 0, 16'h0000, 2'b00, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000);
    tbl[15] = mk(1, 0, 0, 16'h0000, 2'b00, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000);
    for (int i = 16; i <= 19; i++)
      tbl[i] = mk(1, 0, 0, 16'h0000, 2'b01, 1, 16'h0002, 0, 0, 16'h0000, 0, 0, 16'h0000);
    tbl[20] = mk(1, 0, 1, 16'h5A5A, 2'b01, 0, 16'h0002, 1, 0, 16'h5A5A, 0, 0, 16'h0000);
    tbl[21] = mk(0, 1, 0, 16'h0000, 2'b00, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000);
    tbl[22] = mk(0, 1, 0, 16'h0000, 2'b10, 1, 16'h0004, 0, 0, 16'h0000, 0, 0, 16'h0000);
    tbl[23] = mk(0, 0, 0, 16'h0000, 2'b10, 0, 16'h0004, 0, 0, 16'h0000, 0, 0, 16'h0000);
    tbl[24] = mk(0, 0, 0, 16'h0000, 2'b00, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000);

    // Outputs held at zero while in reset, whatever the inputs do.
    rst_n = 1'b0;
    {m0_stb, m1_stb, m0_we, m1_we, io_ack_drv, ack_follow} = 6'b111110;
    {m0_addr, m0_dat, m1_addr, m1_dat, io_dat_in} = {5{16'hFFFF}};
`ifdef IO_ARB_LOCK_EN
    {m0_lock, m1_lock} = '0;
`endif
    repeat (3) @(posedge clk);
    #4 check("in_reset", 128'(dut_vec), 128'(73'd0));

    do_reset();
    m0_we = 1'b1; m0_addr = 16'h0002; m0_dat = 16'h0100;
    m1_we = 1'b0; m1_addr = 16'h0004; m1_dat = 16'h0000;
    for (int i = 0; i < 25; i++) begin
      m0_stb = tbl[i].s0; m1_stb = tbl[i].s1; io_ack_drv = tbl[i].ack; io_dat_in = tbl[i].dat;
      #3;
      check($sformatf("row%0d", i),
            128'({gnt, io_stb, io_addr, m0_ack, m0_err, m0_dat_o, m1_ack, m1_err, m1_dat_o}),
            128'({tbl[i].g, tbl[i].ios, tbl[i].addr, tbl[i].a0, tbl[i].e0, tbl[i].d0,
                  tbl[i].a1, tbl[i].e1, tbl[i].d1}));
      if (tbl[i].g == 2'b01)
        check($sformatf("row%0d_wdata", i), 128'({io_we, io_dat_o}), 128'({1'b1, 16'h0100}));
      @(posedge clk); #1;
    end

    // Both masters request forever, slave acks at once: strict alternation, M0 first.
    do_reset();
    m0_stb = 1'b1; m1_stb = 1'b1; ack_follow = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #3 check($sformatf("rr%0d", i), 128'(gnt), 128'(rr_exp[i]));
      @(posedge clk); #1;
    end
    ack_follow = 1'b0;

    // Reset in the middle of a grant kills the bus at once; release waits for a clock.
    do_reset();
    m0_stb = 1'b1;
    @(posedge clk); #1;
    check("pre_reset_stb", 128'({gnt, io_stb}), 128'({2'b01, 1'b1}));
    io_ack_drv = 1'b1;
    rst_n = 1'b0;
    #1 check("async_reset", 128'(dut_vec), 128'(73'd0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    #2 check("release_idle", 128'(gnt), 128'(2'b00));
    @(posedge clk); #1;
    io_ack_drv = 1'b0;
    #1 check("release_grant", 128'(gnt), 128'(2'b01));

`ifdef IO_ARB_LOCK_EN
    // M0 holds the bus for three acked transfers, then M1 gets its turn.
    do_reset();
    m0_stb = 1'b1; m1_stb = 1'b1; m0_lock = 1'b1; ack_follow = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) m0_lock = 1'b0;
      #3;
      check($sformatf("lock_gnt%0d", i), 128'(gnt),
            128'((i >= 1 && i <= 3) ? 2'b01 : (i == 5) ? 2'b10 : 2'b00));
      check($sformatf("lock_ack%0d", i), 128'(m0_ack), 128'(i >= 1 && i <= 3));
      @(posedge clk); #1;
    end
    do_reset();
    m0_stb = 1'b1; m0_lock = 1'b1; ack_follow = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("lock_reset", 128'(dut_vec), 128'(73'd0));
    ack_follow = 1'b0; m0_lock = 1'b0;
`endif

    // Random traffic against the reference model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      m0_stb = m0_stb ? ($urandom_range(15) != 0) : ($urandom_range(2) == 0);
      m1_stb = m1_stb ? ($urandom_range(15) != 0) : ($urandom_range(2) == 0);
      m0_we = 1'($urandom); m1_we = 1'($urandom);
      m0_addr = 16'($urandom); m1_addr = 16'($urandom);
      m0_dat = 16'($urandom); m1_dat = 16'($urandom);
      io_dat_in = 16'($urandom);
      io_ack_drv = ($urandom_range(3) == 0);
      #3 check($sformatf("rand%0d", c), 128'(dut_vec), 128'(model_out()));
      @(posedge clk);
      model_edge();
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
